// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the multicycle control unit.
// Holds the base opcodes, the FSM state encoding, the instruction classes,
// and the imm_sel, alu_op, result_src and ALU operand select codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_LOAD, C_STORE, C_OP, C_OPIMM, C_LUI,
        C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_SYSTEM
    } cls_t;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction classifier.
// Ports: op/funct3/imm (instruction fields) in; cls (instruction class),
// imm_sel (immediate format), illegal (must trap), halt (ECALL, or EBREAK
// when HALT_ON_EBREAK) out.
module ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter bit HALT_ON_EBREAK = 1'b1
) (
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [11:0] imm,
    output cls_t        cls,
    output logic [2:0]  imm_sel,
    output logic        illegal,
    output logic        halt
);

    always_comb begin
        cls = op == OP_LOAD   ? C_LOAD   :
              op == OP_STORE  ? C_STORE  :
              op == OP_OP     ? C_OP     :
              op == OP_OPIMM  ? C_OPIMM  :
              op == OP_LUI    ? C_LUI    :
              op == OP_AUIPC  ? C_AUIPC  :
              op == OP_JAL    ? C_JAL    :
              op == OP_JALR   ? C_JALR   :
              op == OP_BRANCH ? C_BRANCH :
              op == OP_SYSTEM ? C_SYSTEM : C_NONE;
        imm_sel = (cls inside {C_OPIMM, C_LOAD, C_JALR}) ? IMM_I :
                  cls == C_STORE                       ? IMM_S :
                  cls == C_BRANCH                      ? IMM_B :
                  (cls inside {C_LUI, C_AUIPC})        ? IMM_U :
                  cls == C_JAL                         ? IMM_J : IMM_NONE;
        // ECALL always halts; EBREAK halts only when configured to.
        halt = cls == C_SYSTEM &&
               ((funct3 == 3'b000 && imm == 12'h000) || (imm == 12'h001 && HALT_ON_EBREAK));
        illegal = cls == C_NONE || (cls == C_SYSTEM && !halt);
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a multicycle RV32I datapath.
// Ports: clk, rst_n (sync, active low); op/funct3/imm from the IR;
// mem_ready, branch_taken status in. Out: mem_req/mem_we memory handshake,
// ir_we/pc_we/reg_we register enables, alu_src_a/alu_src_b/alu_op/
// result_src/imm_sel datapath selects, halted/trap terminal flags, state.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT    = 15,
    parameter int HALT_ON_EBREAK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [11:0] imm,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_sel,
    output logic [2:0]  state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        st;
    cls_t          cls;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    dec_imm_sel;
    logic          illegal;
    logic          halt;
    logic          waiting;
    logic          timeout;
    logic          jump;
    logic          ex;
    logic          wb;

    ctrl_decode #(.HALT_ON_EBREAK(HALT_ON_EBREAK != 0)) u_decode (
        .op      (op),
        .funct3  (funct3),
        .imm     (imm),
        .cls     (cls),
        .imm_sel (dec_imm_sel),
        .illegal (illegal),
        .halt    (halt)
    );

    // A ready in the cycle the count would reach the limit still completes.
    always_comb begin
        cnt_nxt = cnt + CW'(1);
        waiting = (st == S_FETCH || st == S_MEMORY) && !mem_ready;
        timeout = waiting && cnt_nxt == CW'(MEM_TIMEOUT);
    end

    // Every non-waiting cycle clears the counter, so any entry into FETCH
    // or MEMORY starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= S_FETCH;
            cnt <= '0;
        end else begin
            cnt <= waiting ? cnt_nxt : '0;
            case (st)
                S_FETCH:     st <= mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
                S_DECODE:    st <= illegal ? S_TRAP : halt ? S_HALT : S_EXECUTE;
                S_EXECUTE:   st <= (cls == C_LOAD || cls == C_STORE) ? S_MEMORY :
                                   cls == C_BRANCH ? S_FETCH : S_WRITEBACK;
                S_MEMORY:    st <= mem_ready ? (cls == C_STORE ? S_FETCH : S_WRITEBACK) :
                                   timeout ? S_TRAP : S_MEMORY;
                S_WRITEBACK: st <= S_FETCH;
                S_HALT:      st <= S_HALT;
                default:     st <= S_TRAP;
            endcase
        end
    end

    // Outputs are forced idle while reset is held, whatever the current state.
    always_comb begin
        jump       = cls == C_JAL || cls == C_JALR;
        ex         = rst_n && st == S_EXECUTE;
        wb         = rst_n && st == S_WRITEBACK;
        mem_req    = rst_n && (st == S_FETCH || st == S_MEMORY);
        mem_we     = rst_n && st == S_MEMORY && cls == C_STORE;
        ir_we      = rst_n && st == S_FETCH && mem_ready;
        pc_we      = (ex && (jump || (cls == C_BRANCH && branch_taken))) ||
                     (mem_we && mem_ready) || (wb && !jump);
        reg_we     = wb;
        halted     = rst_n && st == S_HALT;
        trap       = rst_n && st == S_TRAP;
        alu_op     = !ex ? ALU_ADD :
                     (cls == C_OP || cls == C_OPIMM) ? ALU_FUNC :
                     cls == C_BRANCH ? ALU_BR : ALU_ADD;
        alu_src_a  = !ex ? SRC_A_RS1 :
                     cls == C_LUI ? SRC_A_ZERO :
                     (cls inside {C_AUIPC, C_JAL, C_BRANCH}) ? SRC_A_PC : SRC_A_RS1;
        alu_src_b  = (!ex || cls == C_OP) ? SRC_B_RS2 : SRC_B_IMM;
        result_src = !wb ? RES_ALU : cls == C_LOAD ? RES_LOAD : jump ? RES_PC4 : RES_ALU;
        imm_sel    = (rst_n && (st inside {S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK})) ?
                     dec_imm_sel : IMM_NONE;
        state      = st;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: builds the expected per-cycle trace of each
// instruction from the control rules and compares the DUT against it.
module tb_multicycle_control;

    localparam int TO  = 4;
    localparam bit HOE = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic [11:0] imm = '0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we, halted, trap;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]  imm_sel, state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic mreq, mwe, irwe, pcwe, regwe, hlt, trp;
        logic [1:0] a, b, aop, rs;
        logic [2:0] isel;
    } out_t;

    typedef struct packed {
        logic rst_n, rdy, bt, cs;
        logic [2:0] st;
        out_t o;
    } cyc_t;

    cyc_t q[$];
    out_t obs;

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, ir_we, pc_we, reg_we, halted, trap,
                  alu_src_a, alu_src_b, alu_op, result_src, imm_sel};

    multicycle_control #(.MEM_TIMEOUT(TO), .HALT_ON_EBREAK(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .imm          (imm),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .reg_we       (reg_we),
        .halted       (halted),
        .trap         (trap),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .result_src   (result_src),
        .imm_sel      (imm_sel),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, o, e);
        end
    endtask

    function automatic cyc_t mk(input logic [2:0] s, input logic b);
        cyc_t c;
        c = '0;
        c.rst_n = 1'b1;
        c.rdy = 1'($urandom);
        c.bt = b;
        c.cs = 1'b1;
        c.st = s;
        return c;
    endfunction

    // Drive the queued cycles; inputs change on the falling edge and outputs
    // are sampled 1 ns later, well away from the rising edge.
    task automatic play(input logic [6:0] o, input logic [2:0] f, input logic [11:0] im);
        foreach (q[i]) begin
            @(negedge clk);
            if (i == 0) begin
                op = o;
                funct3 = f;
                imm = im;
            end
            rst_n = q[i].rst_n;
            mem_ready = q[i].rdy;
            branch_taken = q[i].bt;
            #1;
            cyc++;
            if (q[i].cs) chk("state", 32'(state), 32'(q[i].st));
            chk("outputs", 32'(obs), 32'(q[i].o));
        end
    endtask

    // wf/wm: memory wait cycles before ready in fetch/memory (>= TO times out);
    // rst_at: trace index at which reset is asserted instead (-1 for none).
    task automatic run(input logic [6:0] o, input logic [2:0] f, input logic [11:0] im,
                       input logic b, input int wf, input int wm, input int rst_at);
        logic ld, sto, alu, alui, lui, aui, jal, jalr, br, sy, legal, sys_halt;
        logic [2:0] isel, term, s;
        cyc_t c;
        q.delete();
        ld = o == 7'h03; sto = o == 7'h23; alu = o == 7'h33; alui = o == 7'h13;
        lui = o == 7'h37; aui = o == 7'h17; jal = o == 7'h6f; jalr = o == 7'h67;
        br = o == 7'h63; sy = o == 7'h73;
        legal = ld | sto | alu | alui | lui | aui | jal | jalr | br | sy;
        sys_halt = sy && ((f == 3'd0 && im == 12'd0) || (im == 12'd1 && HOE));
        isel = (ld || alui || jalr) ? 3'd1 : sto ? 3'd2 : br ? 3'd3 :
               (lui || aui) ? 3'd4 : jal ? 3'd5 : 3'd0;
        term = 3'd0;
        for (int i = 0; i < wf && i < TO; i++) begin
            c = mk(3'd0, b); c.rdy = 1'b0; c.o.mreq = 1'b1; q.push_back(c);
        end
        if (wf >= TO) term = 3'd6;
        else begin
            c = mk(3'd0, b); c.rdy = 1'b1; c.o.mreq = 1'b1; c.o.irwe = 1'b1; q.push_back(c);
            c = mk(3'd1, b); c.o.isel = isel; q.push_back(c);
            if (!legal || (sy && !sys_halt)) term = 3'd6;
            else if (sy) term = 3'd5;
            else begin
                c = mk(3'd2, b);
                c.o.isel = isel;
                c.o.a = lui ? 2'd2 : (aui || jal || br) ? 2'd1 : 2'd0;
                c.o.b = alu ? 2'd0 : 2'd1;
                c.o.aop = (alu || alui) ? 2'd2 : br ? 2'd1 : 2'd0;
                c.o.pcwe = jal || jalr || (br && b);
                q.push_back(c);
                if (ld || sto) begin
                    for (int i = 0; i < wm && i < TO; i++) begin
                        c = mk(3'd3, b); c.rdy = 1'b0; c.o.mreq = 1'b1; c.o.mwe = sto;
                        c.o.isel = isel; q.push_back(c);
                    end
                    if (wm >= TO) term = 3'd6;
                    else begin
                        c = mk(3'd3, b); c.rdy = 1'b1; c.o.mreq = 1'b1; c.o.mwe = sto;
                        c.o.pcwe = sto; c.o.isel = isel; q.push_back(c);
                    end
                end
                if (term == 3'd0 && !br && !sto) begin
                    c = mk(3'd4, b);
                    c.o.isel = isel;
                    c.o.regwe = 1'b1;
                    c.o.pcwe = !(jal || jalr);
                    c.o.rs = ld ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0;
                    q.push_back(c);
                end
            end
        end
        if (term != 3'd0) begin
            for (int i = 0; i < 3; i++) begin
                c = mk(term, b); c.o.hlt = term == 3'd5; c.o.trp = term == 3'd6; q.push_back(c);
            end
            c = mk(term, b); c.rst_n = 1'b0; q.push_back(c);
        end
        if (rst_at >= 0 && rst_at < q.size()) begin
            s = q[rst_at].st;
            while (q.size() > rst_at) void'(q.pop_back());
            c = mk(s, b); c.rst_n = 1'b0; q.push_back(c);
        end
        play(o, f, im);
    endtask

    initial begin
        logic [6:0] ops [12] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17,
                                 7'h6f, 7'h67, 7'h63, 7'h73, 7'h7f, 7'h00};
        cyc_t c;
        logic [6:0] o;
        logic [11:0] im;
        int k;
        q.delete();
        c = mk(3'd0, 1'b0); c.rst_n = 1'b0; c.cs = 1'b0; q.push_back(c);
        c.cs = 1'b1; q.push_back(c);
        play(7'h00, 3'd0, 12'd0);
        run(7'h13, 3'd0, 12'h005, 1'b0, 0, 0, -1);
        run(7'h03, 3'd2, 12'h004, 1'b0, 0, 3, -1);
        run(7'h63, 3'd0, 12'h010, 1'b1, 1, 0, -1);
        run(7'h63, 3'd0, 12'h010, 1'b0, 0, 0, -1);
        run(7'h13, 3'd0, 12'h001, 1'b0, TO, 0, -1);
        run(7'h13, 3'd0, 12'h001, 1'b0, TO - 1, 0, -1);
        run(7'h73, 3'd0, 12'h000, 1'b0, 0, 0, -1);
        run(7'h73, 3'd0, 12'h001, 1'b0, 0, 0, -1);
        run(7'h7f, 3'd0, 12'h000, 1'b0, 0, 0, -1);
        run(7'h23, 3'd2, 12'h008, 1'b0, 0, 2, 4);
        run(7'h23, 3'd2, 12'h008, 1'b0, 0, 2, 5);
        run(7'h6f, 3'd0, 12'h000, 1'b0, 0, 0, -1);
        run(7'h67, 3'd0, 12'h000, 1'b0, 0, 0, -1);
        run(7'h23, 3'd2, 12'h000, 1'b0, 0, TO, -1);
        for (int n = 0; n < 200; n++) begin
            o = ($urandom % 16 == 0) ? 7'($urandom) : ops[$urandom % 12];
            k = $urandom % 3;
            im = k == 0 ? 12'd0 : k == 1 ? 12'd1 : 12'($urandom);
            run(o, 3'($urandom), im, 1'($urandom),
                ($urandom % 8 == 0) ? TO : int'($urandom_range(0, TO - 1)),
                ($urandom % 8 == 0) ? TO : int'($urandom_range(0, TO - 1)),
                ($urandom % 8 == 0) ? int'($urandom_range(0, 8)) : -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
